// File: rtl/spram_ctrl_pkg.sv
// Shared types and defaults for the single-port SRAM arbiter/sequencer.
package spram_ctrl_pkg;
  localparam int NUM_PORTS  = 2;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {INIT, RUN} state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, pointer moves to the other port after any grant.
// Latency: combinational grant; pointer updates on the grant edge. No backpressure of its own.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant    = eligible;
    rr_ptr_d = rr_ptr_q;
    if (eligible == 2'b11) begin
      grant = rr_ptr_q ? 2'b10 : 2'b01;
    end
    if (grant[0]) begin
      rr_ptr_d = 1'b1;
    end else if (grant[1]) begin
      rr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 1'b0;
    else        rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: rtl/spram_arb_ctrl.sv
// Shares one single-port SRAM between two valid/ready requesters, optionally zero-fills it after reset.
// Read accept-to-response latency 2 cycles; one read in flight per port, held until rsp_ready.
module spram_arb_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata0,
  output logic [DATA_W-1:0] rsp_rdata1,
  output logic              init_done,
  output logic              mem_ceb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q
);
  localparam state_e RST_STATE = INIT_CLEAR ? INIT : RUN;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [1:0]          rd_pend_q, rd_pend_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q [NUM_PORTS];
  logic [DATA_W-1:0]   rsp_rdata_d [NUM_PORTS];
  logic [ADDR_W-1:0]   mem_a_q, mem_a_int;
  logic [DATA_W-1:0]   mem_d_q, mem_d_int;
  logic                mem_ceb_int, mem_web_int;
  logic [ADDR_W-1:0]   addr_m  [NUM_PORTS];
  logic [DATA_W-1:0]   wdata_m [NUM_PORTS];
  logic [1:0]          eligible, grant;
  logic                g;

  assign addr_m[0]  = req_addr0;
  assign addr_m[1]  = req_addr1;
  assign wdata_m[0] = req_wdata0;
  assign wdata_m[1] = req_wdata1;

  // A read may issue only if its response slot will be free by the time data returns.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = (state_q == RUN) && req_valid[p] &&
                    (req_we[p] || (!rd_pend_q[p] && (!rsp_valid_q[p] || rsp_ready[p])));
    end
  end

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .grant    (grant)
  );

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    mem_ceb_int = 1'b1;
    mem_web_int = 1'b1;
    mem_a_int   = mem_a_q;
    mem_d_int   = mem_d_q;
    rd_pend_d   = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    g           = grant[1];

    if (state_q == INIT) begin
      mem_ceb_int = 1'b0;
      mem_web_int = 1'b0;
      mem_a_int   = clr_cnt_q;
      mem_d_int   = '0;
      clr_cnt_d   = clr_cnt_q + 1'b1;
      if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = RUN;
    end else if (|grant) begin
      mem_ceb_int  = 1'b0;
      mem_web_int  = ~req_we[g];
      mem_a_int    = addr_m[g];
      mem_d_int    = wdata_m[g];
      rd_pend_d[g] = ~req_we[g];
    end

    // A capture outranks a drain in the same cycle.
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rd_pend_q[p]) begin
        rsp_valid_d[p] = 1'b1;
        rsp_rdata_d[p] = mem_q;
      end else if (rsp_valid_q[p] && rsp_ready[p]) begin
        rsp_valid_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= '0;
      rd_pend_q   <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '{default: '0};
      mem_a_q     <= '0;
      mem_d_q     <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_a_q     <= mem_a_int;
      mem_d_q     <= mem_d_int;
    end
  end

  // Outputs are forced idle while reset is held, even though state already reads INIT.
  assign req_ready  = grant & {2{rst_n}};
  assign mem_ceb    = mem_ceb_int | ~rst_n;
  assign mem_web    = mem_web_int | ~rst_n;
  assign mem_a      = rst_n ? mem_a_int : '0;
  assign mem_d      = rst_n ? mem_d_int : '0;
  assign init_done  = rst_n && (state_q == RUN);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata0 = rsp_rdata_q[0];
  assign rsp_rdata1 = rsp_rdata_q[1];
endmodule

// File: doc/spram_arb_ctrl.md
Name: spram_arb_ctrl

Overview:
- Two-port arbiter and sequencer for one single-port synchronous SRAM (32x32 by default, t22_s1pram32x32_wrapper style: active-low CEB/WEB, 1-cycle read latency).
- Shares the macro between two requesters using valid/ready handshakes and round-robin priority.
- Optionally zero-fills the array after reset.
- Returns read data through a backpressurable one-entry response register per port.

Parameters:
- ADDR_W, 5, SRAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 32, SRAM data width.
- INIT_CLEAR, 1, 1 = write zeros to every address after reset before accepting requests.

Ports:
- clk  in  1  single clock; also drives the SRAM wrapper CLK.
- rst_n  in  1  asynchronous active-low reset.
- req_valid[1:0]  in  2  per-port request valid.
- req_ready[1:0]  out  2  per-port request accepted this cycle.
- req_we[1:0]  in  2  1 = write, 0 = read.
- req_addr0, req_addr1  in  ADDR_W each  request address.
- req_wdata0, req_wdata1  in  DATA_W each  write data.
- rsp_valid[1:0]  out  2  read data valid.
- rsp_ready[1:0]  in  2  consumer accepts the read data.
- rsp_rdata0, rsp_rdata1  out  DATA_W each  read data.
- init_done  out  1  high once the clear sequence is finished (or immediately if INIT_CLEAR=0).
- mem_ceb  out  1  SRAM chip enable, active low.
- mem_web  out  1  SRAM write enable, active low.
- mem_a  out  ADDR_W  SRAM address.
- mem_d  out  DATA_W  SRAM write data.
- mem_q  in  DATA_W  SRAM read data, valid the cycle after a read access.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata*=0, init_done=0, mem_ceb=1, mem_web=1, mem_a=0, mem_d=0. Internal state: rr_ptr=0, rd_pend=0, clr_cnt=0, state=INIT (or RUN when INIT_CLEAR=0).
- FSM:
  - INIT: each cycle drive mem_ceb=0, mem_web=0, mem_a=clr_cnt, mem_d=0; clr_cnt++. After address DEPTH-1 is written, go to RUN next cycle. In INIT, req_ready=0.
  - RUN: init_done=1 and stays 1 until reset.
- Eligibility (RUN only):
  - Write on port p is eligible when req_valid[p]=1.
  - Read on port p is eligible when req_valid[p]=1, rd_pend[p]=0 and (rsp_valid[p]=0 or rsp_ready[p]=1).
  - At most one outstanding read per port.
- Arbitration:
  - If only one port is eligible, grant it.
  - If both are eligible, grant port rr_ptr.
  - After any grant, rr_ptr <= ~granted port.
  - If neither is eligible, rr_ptr is unchanged.
  - req_ready is combinational: one-hot for the granted port, else 0. Exactly one access per cycle.
- Memory drive (combinational in the grant cycle T):
  - mem_ceb=0; mem_web=~req_we[g]; mem_a=req_addr[g]; mem_d=req_wdata[g].
  - With no grant and no INIT: mem_ceb=1, mem_web=1, mem_a/mem_d hold their last values.
- Read pipeline:
  - At the end of T, rd_pend[g] <= 1.
  - In T+1, mem_q is captured into rsp_rdata[g] at the closing edge; rsp_valid[g] <= 1 and rd_pend[g] <= 0.
  - rsp_valid is first high in cycle T+2, so accept-to-response latency is 2 cycles.
  - rsp_valid[p] falls after a cycle with rsp_valid[p] & rsp_ready[p], unless a new capture happens in the same cycle; the capture wins and rsp_valid stays 1.
  - rsp_rdata is stable while rsp_valid=1 and rsp_ready=0.
- Writes produce no response. A read after a write to the same address (any port, any later cycle) returns the new data, because the macro is single-port and accesses are serialized.
- Reset asserted mid-operation: all state returns to reset values asynchronously; any pending read is discarded; the clear sequence restarts after rst_n deasserts.
- No combinational path from rsp_ready to mem_* other than through eligibility.

Decomposition:
- Shared package spram_ctrl_pkg holds:
  - typedef state_e {INIT, RUN};
  - localparam NUM_PORTS=2;
  - the default ADDR_W/DATA_W constants.
- Sub-module rr_arb2 (2-input round-robin arbiter: eligible[1:0], rr_ptr -> grant one-hot, updates pointer) is natural. Everything else stays in the top.

Test Plan:
- Post-reset clear, INIT_CLEAR=1: rst_n released -> mem_ceb=0, mem_web=0 for exactly 32 cycles with addresses 0..31 and data 0. init_done rises the next cycle. A read of address 7 returns 0x00000000.
- Single-port write then read: port0 writes 0xDEADBEEF to address 5, then reads address 5 with rsp_ready=1 -> rsp_valid[0] high 2 cycles after read accept, rsp_rdata0=0xDEADBEEF.
- Contention: both ports hold valid reads (address 1, address 2) for 4 cycles with rsp_ready=1 -> grants follow rr_ptr, alternating 0,1,0,1 where eligibility allows; mem_a shows each address in grant order. No cycle has both req_ready bits high.
- Backpressure: port1 reads address 3, then holds rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and rsp_rdata1 stay stable. A second port1 read keeps req_ready[1]=0 while port0 writes are still granted.
- Same-cycle drain and refill: rsp_valid[0]=1 with rsp_ready[0]=1 while a new port0 read completes capture -> rsp_valid[0] remains 1 and carries the new data.
- Reset mid-read: assert rst_n low in the cycle after a read accept -> rsp_valid=0 and mem_ceb=1 immediately. After release, no stale response appears and INIT reruns.
